// File: rtl/hamming_enc_engine.sv
// hamming_enc_engine: reads 11-bit messages from data memory and writes back
// 16-bit SECDED Hamming codewords; it is the sole memory master while busy.
module hamming_enc_engine #(
    parameter int unsigned NUM_WORDS = 15,
    parameter logic [7:0]  SRC_BASE  = 8'd0,
    parameter logic [7:0]  DST_BASE  = 8'd30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] mem_address,
    output logic       mem_read_en,
    output logic       mem_write_en,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    state_t      state;
    state_t      state_nx;
    logic [5:0]  index;
    logic [5:0]  index_nx;
    logic [7:0]  d_lo;
    logic [2:0]  d_hi;
    logic [10:0] d;
    logic        p8;
    logic        p4;
    logic        p2;
    logic        p1;
    logic        p0;
    logic [7:0]  cw_lo;
    logic [7:0]  cw_hi;
    logic [7:0]  offset;

    // state, word index and captured message bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            index <= '0;
            d_lo  <= '0;
            d_hi  <= '0;
        end else begin
            state <= state_nx;
            index <= index_nx;
            if (state == RD_LO) begin
                d_lo <= mem_rdata;
            end
            if (state == RD_HI) begin
                d_hi <= mem_rdata[2:0];
            end
        end
    end

    // next-state and index sequencing
    always_comb begin
        state_nx = state;
        index_nx = index;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RD_LO;
                    index_nx = '0;
                end
            end
            RD_LO: state_nx = RD_HI;
            RD_HI: state_nx = WR_LO;
            WR_LO: state_nx = WR_HI;
            WR_HI: begin
                if (index == LAST_IDX) begin
                    state_nx = DONE;
                end else begin
                    state_nx = RD_LO;
                    index_nx = index + 6'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Hamming(15,11) parity plus overall parity for double-error detection
    always_comb begin
        d     = {d_hi, d_lo};
        p8    = ^d[10:4];
        p4    = ^{d[10:7], d[3:1]};
        p2    = ^{d[10:9], d[6:5], d[3:2], d[0]};
        p1    = ^{d[10], d[8], d[6], d[4], d[3], d[1], d[0]};
        p0    = ^{d, p8, p4, p2, p1};
        cw_hi = {d[10:4], p8};
        cw_lo = {d[3:1], p4, d[0], p2, p1, p0};
    end

    // Moore outputs decoded from state and index only
    always_comb begin
        offset       = {1'b0, index, 1'b0};
        busy         = 1'b0;
        done         = 1'b0;
        mem_address  = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_wdata    = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            RD_LO: begin
                busy        = 1'b1;
                mem_read_en = 1'b1;
                mem_address = SRC_BASE + offset;
            end
            RD_HI: begin
                busy        = 1'b1;
                mem_read_en = 1'b1;
                mem_address = SRC_BASE + offset + 8'd1;
            end
            WR_LO: begin
                busy         = 1'b1;
                mem_write_en = 1'b1;
                mem_address  = DST_BASE + offset;
                mem_wdata    = cw_lo;
            end
            WR_HI: begin
                busy         = 1'b1;
                mem_write_en = 1'b1;
                mem_address  = DST_BASE + offset + 8'd1;
                mem_wdata    = cw_hi;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
